midi_voice_alloc: RTL and testbench

- Front end of the synth's note path. Consumes the raw MIDI byte stream from the UART receiver and parses channel Note On and Note Off messages.
- Assigns each note to one of NUMREADS voice slots and drives the per-slot 7-bit note numbers that feed the note-to-phase-increment lookup, plus per-slot gate, velocity and retrigger signals for the envelope generators.

---
 rtl/midi_pkg.sv | 17 +
 rtl/midi_byte_parser.sv | 76 +++++++
 rtl/midi_voice_alloc.sv | 104 ++++++++++
 tb/tb_midi_voice_alloc.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// Shared MIDI definitions for the note path: status nibbles, note type and
// the byte parser's state encoding.
package midi_pkg;

  localparam logic [3:0] MIDI_NOTE_OFF  = 4'h8;
  localparam logic [3:0] MIDI_NOTE_ON   = 4'h9;
  localparam logic [7:0] MIDI_SYSRT_MIN = 8'hF8;

  typedef logic [6:0] midi_note_t;

  typedef enum logic [1:0] {
    WAIT_STATUS = 2'd0,
    WAIT_D1     = 2'd1,
    WAIT_D2     = 2'd2
  } midi_parse_state_t;

endpackage

// File: rtl/midi_byte_parser.sv
// MIDI byte-stream parser with running status. Emits a one-cycle note event
// (is_on, note, vel) for Note On/Off messages on the accepted channel.
module midi_byte_parser
  import midi_pkg::*;
#(
  parameter int MIDI_CHANNEL = 0,
  parameter int OMNI         = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        rx_byte,
  input  logic              rx_valid,
  output logic              ev_valid,
  output logic              ev_is_on,
  output midi_note_t        ev_note,
  output midi_note_t        ev_vel,
  output midi_parse_state_t state
);

  logic [7:0] run_status;
  midi_note_t d1;
  logic [3:0] msg_type;
  logic       one_data_byte;
  logic       is_note_msg;
  logic       chan_ok;

  assign msg_type      = run_status[7:4];
  assign one_data_byte = (msg_type == 4'hC) || (msg_type == 4'hD);
  assign is_note_msg   = (msg_type == MIDI_NOTE_ON) || (msg_type == MIDI_NOTE_OFF);
  assign chan_ok       = (OMNI != 0) || (run_status[3:0] == 4'(MIDI_CHANNEL));

  // Status bytes behave identically in every state; realtime bytes are invisible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= WAIT_STATUS;
      run_status <= '0;
      d1         <= '0;
      ev_valid   <= 1'b0;
      ev_is_on   <= 1'b0;
      ev_note    <= '0;
      ev_vel     <= '0;
    end else begin
      ev_valid <= 1'b0;
      if (rx_valid && (rx_byte < MIDI_SYSRT_MIN)) begin
        if (rx_byte[7]) begin
          if (rx_byte >= 8'hF0) begin
            run_status <= '0;
            state      <= WAIT_STATUS;
          end else begin
            run_status <= rx_byte;
            state      <= WAIT_D1;
          end
        end else begin
          case (state)
            WAIT_STATUS: state <= WAIT_STATUS;
            WAIT_D1: begin
              if (!one_data_byte) begin
                d1    <= rx_byte[6:0];
                state <= WAIT_D2;
              end
            end
            WAIT_D2: begin
              ev_valid <= is_note_msg && chan_ok;
              ev_is_on <= (msg_type == MIDI_NOTE_ON) && (rx_byte[6:0] != 7'd0);
              ev_note  <= d1;
              ev_vel   <= rx_byte[6:0];
              state    <= WAIT_D1;
            end
            default: state <= WAIT_STATUS;
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/midi_voice_alloc.sv
// Voice allocator: parses MIDI note messages and assigns them to NUMREADS
// voice slots driving note numbers, gates, velocities and retrigger pulses.
module midi_voice_alloc
  import midi_pkg::*;
#(
  parameter int NUMREADS     = 4,
  parameter int MIDI_CHANNEL = 0,
  parameter int OMNI         = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        rx_byte,
  input  logic              rx_valid,
  output midi_note_t        midi_notenums [0:NUMREADS-1],
  output logic [NUMREADS-1:0] gates,
  output midi_note_t        velocities [0:NUMREADS-1],
  output logic [NUMREADS-1:0] trigs,
  output midi_parse_state_t parse_state
);

  localparam int PW = (NUMREADS > 1) ? $clog2(NUMREADS) : 1;

  // Handshake: ev_valid is a single-cycle strobe; is_on/note/vel are only
  // meaningful in that cycle and there is no backpressure.
  logic       ev_valid;
  logic       ev_is_on;
  midi_note_t ev_note;
  midi_note_t ev_vel;

  logic [PW-1:0] steal_ptr;
  logic [PW-1:0] steal_next;
  logic [PW-1:0] hit_idx;
  logic [PW-1:0] free_idx;
  logic [PW-1:0] sel_idx;
  logic          hit_found;
  logic          free_found;

  midi_byte_parser #(
    .MIDI_CHANNEL (MIDI_CHANNEL),
    .OMNI         (OMNI)
  ) u_parser (
    .clk      (clk),
    .reset_n  (reset_n),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .ev_valid (ev_valid),
    .ev_is_on (ev_is_on),
    .ev_note  (ev_note),
    .ev_vel   (ev_vel),
    .state    (parse_state)
  );

  // Descending scans leave the lowest matching index in each result.
  always_comb begin
    hit_found  = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUMREADS - 1; i >= 0; i--) begin
      if (gates[i] && (midi_notenums[i] == ev_note)) begin
        hit_found = 1'b1;
        hit_idx   = PW'(i);
      end
      if (!gates[i]) begin
        free_found = 1'b1;
        free_idx   = PW'(i);
      end
    end
    if (hit_found)       sel_idx = hit_idx;
    else if (free_found) sel_idx = free_idx;
    else                 sel_idx = steal_ptr;
  end

  assign steal_next = (steal_ptr == PW'(NUMREADS - 1)) ? '0 : steal_ptr + PW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUMREADS; i++) begin
        midi_notenums[i] <= '0;
        velocities[i]    <= '0;
      end
      gates     <= '0;
      trigs     <= '0;
      steal_ptr <= '0;
    end else begin
      trigs <= '0;
      if (ev_valid) begin
        if (ev_is_on) begin
          midi_notenums[sel_idx] <= ev_note;
          velocities[sel_idx]    <= ev_vel;
          gates[sel_idx]         <= 1'b1;
          trigs[sel_idx]         <= 1'b1;
          if (!hit_found && !free_found) steal_ptr <= steal_next;
        end else begin
          // Note-off keeps pitch and velocity so the release tail stays in tune.
          for (int i = 0; i < NUMREADS; i++) begin
            if (gates[i] && (midi_notenums[i] == ev_note)) gates[i] <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_midi_voice_alloc.sv
// Bench for midi_voice_alloc: a channel-0 instance and an OMNI instance share
// the byte stream and are compared against a message-level voice model.
module tb_midi_voice_alloc;
  import midi_pkg::*;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_valid = 1'b0;

  midi_note_t        notes0 [0:N-1];
  midi_note_t        notes1 [0:N-1];
  midi_note_t        vels0  [0:N-1];
  midi_note_t        vels1  [0:N-1];
  logic [N-1:0]      gates0, gates1, trigs0, trigs1;
  midi_parse_state_t st0, st1;

  midi_voice_alloc #(.NUMREADS(N), .MIDI_CHANNEL(0), .OMNI(0)) dut (
    .clk(clk), .reset_n(reset_n), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .midi_notenums(notes0), .gates(gates0), .velocities(vels0), .trigs(trigs0),
    .parse_state(st0)
  );

  midi_voice_alloc #(.NUMREADS(N), .MIDI_CHANNEL(0), .OMNI(1)) dut_omni (
    .clk(clk), .reset_n(reset_n), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .midi_notenums(notes1), .gates(gates1), .velocities(vels1), .trigs(trigs1),
    .parse_state(st1)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Reference model: index 0 = channel-0 instance, index 1 = OMNI instance
  logic [6:0] m_note [2][N];
  logic [6:0] m_vel  [2][N];
  logic       m_gate [2][N];
  int         m_ptr  [2];
  logic [7:0] exp_q[$];
  logic [7:0] last_status;
  logic [7:0] exp_t;
  int checks = 0;
  int passes = 0;

  function automatic logic [15:0] act_slot(int k, int i);
    if (k == 0) return {notes0[i], vels0[i], gates0[i], trigs0[i]};
    return {notes1[i], vels1[i], gates1[i], trigs1[i]};
  endfunction

  function automatic logic [15:0] exp_slot(int k, int i, logic [7:0] t);
    return {m_note[k][i], m_vel[k][i], m_gate[k][i], t[k*N+i]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ptr[k] = 0;
      for (int i = 0; i < N; i++) begin
        m_note[k][i] = 0;
        m_vel[k][i]  = 0;
        m_gate[k][i] = 0;
      end
    end
    last_status = 8'h00;
    exp_q.delete();
  endtask

  task automatic model_event(input int k, input bit on, input logic [6:0] n,
                             input logic [6:0] v, output logic [N-1:0] trig);
    int sel;
    trig = '0;
    if (on) begin
      sel = -1;
      for (int i = 0; i < N; i++)
        if (sel < 0 && m_gate[k][i] && m_note[k][i] == n) sel = i;
      for (int i = 0; i < N; i++)
        if (sel < 0 && !m_gate[k][i]) sel = i;
      if (sel < 0) begin
        sel = m_ptr[k];
        m_ptr[k] = (m_ptr[k] + 1) % N;
      end
      m_note[k][sel] = n;
      m_vel[k][sel]  = v;
      m_gate[k][sel] = 1'b1;
      trig[sel]      = 1'b1;
    end else begin
      for (int i = 0; i < N; i++)
        if (m_gate[k][i] && m_note[k][i] == n) m_gate[k][i] = 1'b0;
    end
  endtask

  // Driver tasks: called at a negedge, return at the following negedge
  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic maybe_rt(input bit en);
    if (en && $urandom_range(0, 3) == 0) send_byte(8'($urandom_range(248, 255)));
  endtask

  task automatic send_msg(input logic [7:0] st, input bit use_status,
                          input logic [6:0] d1, input logic [6:0] d2, input bit rt);
    logic [N-1:0] t0, t1;
    bit on;
    t0 = '0;
    t1 = '0;
    if (use_status) begin
      send_byte(st);
      last_status = st;
    end
    maybe_rt(rt);
    send_byte({1'b0, d1});
    if (st[7:4] != 4'hC && st[7:4] != 4'hD) begin
      maybe_rt(rt);
      send_byte({1'b0, d2});
      if (st[7:4] == 4'h8 || st[7:4] == 4'h9) begin
        on = (st[7:4] == 4'h9) && (d2 != 7'd0);
        if (st[3:0] == 4'h0) model_event(0, on, d1, d2, t0);
        model_event(1, on, d1, d2, t1);
      end
    end
    exp_q.push_back({t1, t0});
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++) begin
        checks++;
        if (act_slot(k, i) !== exp_slot(k, i, 8'h00))
          $display("FAIL reset dut%0d slot%0d got=%h exp=%h", k, i, act_slot(k, i), exp_slot(k, i, 8'h00));
        else passes++;
      end
    checks++;
    if ({st1, st0} !== {WAIT_STATUS, WAIT_STATUS})
      $display("FAIL reset_state got=%0d/%0d exp=%0d", st0, st1, WAIT_STATUS);
    else passes++;
  endtask

  task automatic test_basic();
    send_msg(8'h90, 1'b1, 7'd60, 7'd100, 1'b0);
    checks++;
    if ({trigs1, trigs0, gates1, gates0} !== 16'h0)
      $display("FAIL basic_early got trigs=%b/%b gates=%b/%b exp=0", trigs0, trigs1, gates0, gates1);
    else passes++;
    @(negedge clk);
    exp_t = exp_q.pop_front();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++) begin
        checks++;
        if (act_slot(k, i) !== exp_slot(k, i, exp_t))
          $display("FAIL basic dut%0d slot%0d got=%h exp=%h", k, i, act_slot(k, i), exp_slot(k, i, exp_t));
        else passes++;
      end
    @(negedge clk);
    checks++;
    if ({trigs1, trigs0} !== 8'h00) $display("FAIL basic_trig_clear got=%b/%b exp=0", trigs0, trigs1);
    else passes++;
  endtask

  task automatic test_running_status();
    logic [6:0] rs_notes [2] = '{7'd64, 7'd60};
    logic [6:0] rs_vels  [2] = '{7'd80, 7'd0};
    for (int m = 0; m < 2; m++) begin
      send_msg(8'h90, 1'b0, rs_notes[m], rs_vels[m], 1'b0);
      @(negedge clk);
      exp_t = exp_q.pop_front();
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < N; i++) begin
          checks++;
          if (act_slot(k, i) !== exp_slot(k, i, exp_t))
            $display("FAIL running_status msg%0d dut%0d slot%0d got=%h exp=%h", m, k, i, act_slot(k, i), exp_slot(k, i, exp_t));
          else passes++;
        end
      @(negedge clk);
    end
  endtask

  task automatic test_steal();
    logic [6:0] seq [6] = '{7'd60, 7'd62, 7'd64, 7'd65, 7'd67, 7'd69};
    do_reset();
    for (int m = 0; m < 6; m++) begin
      send_msg(8'h90, (m == 0), seq[m], 7'(90 + m), 1'b0);
      @(negedge clk);
      exp_t = exp_q.pop_front();
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < N; i++) begin
          checks++;
          if (act_slot(k, i) !== exp_slot(k, i, exp_t))
            $display("FAIL steal note%0d dut%0d slot%0d got=%h exp=%h", seq[m], k, i, act_slot(k, i), exp_slot(k, i, exp_t));
          else passes++;
        end
      @(negedge clk);
    end
  endtask

  task automatic test_realtime();
    logic [N-1:0] t0, t1;
    do_reset();
    send_byte(8'h90);
    send_byte(8'h3C);
    send_byte(8'hF8);
    send_byte(8'h64);
    model_event(0, 1'b1, 7'd60, 7'd100, t0);
    model_event(1, 1'b1, 7'd60, 7'd100, t1);
    exp_q.push_back({t1, t0});
    @(negedge clk);
    exp_t = exp_q.pop_front();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++) begin
        checks++;
        if (act_slot(k, i) !== exp_slot(k, i, exp_t))
          $display("FAIL realtime dut%0d slot%0d got=%h exp=%h", k, i, act_slot(k, i), exp_slot(k, i, exp_t));
        else passes++;
      end
    @(negedge clk);
  endtask

  task automatic test_channel();
    do_reset();
    send_msg(8'h91, 1'b1, 7'd60, 7'd100, 1'b0);
    @(negedge clk);
    exp_t = exp_q.pop_front();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++) begin
        checks++;
        if (act_slot(k, i) !== exp_slot(k, i, exp_t))
          $display("FAIL channel dut%0d slot%0d got=%h exp=%h", k, i, act_slot(k, i), exp_slot(k, i, exp_t));
        else passes++;
      end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [7:0] st;
    logic [3:0] typ;
    logic [6:0] vel;
    int r;
    do_reset();
    for (int m = 0; m < 150; m++) begin
      r   = $urandom_range(0, 9);
      typ = (r == 0) ? 4'hC : (r <= 3) ? 4'h8 : 4'h9;
      st  = {typ, ($urandom_range(0, 3) == 0) ? 4'h1 : 4'h0};
      vel = ($urandom_range(0, 5) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
      send_msg(st, !(last_status == st && $urandom_range(0, 1) == 1),
               7'(60 + $urandom_range(0, 7)), vel, 1'b1);
      @(negedge clk);
      exp_t = exp_q.pop_front();
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < N; i++) begin
          checks++;
          if (act_slot(k, i) !== exp_slot(k, i, exp_t))
            $display("FAIL random msg%0d st=%h dut%0d slot%0d got=%h exp=%h", m, st, k, i, act_slot(k, i), exp_slot(k, i, exp_t));
          else passes++;
        end
      @(negedge clk);
      checks++;
      if ({trigs1, trigs0} !== 8'h00) $display("FAIL random_trig_clear msg%0d got=%b/%b exp=0", m, trigs0, trigs1);
      else passes++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_byte(8'h90);
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    send_byte(8'h3C);
    send_byte(8'h64);
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++) begin
        checks++;
        if (act_slot(k, i) !== exp_slot(k, i, 8'h00))
          $display("FAIL reset_mid dut%0d slot%0d got=%h exp=%h", k, i, act_slot(k, i), exp_slot(k, i, 8'h00));
        else passes++;
      end
    checks++;
    if ({st1, st0} !== {WAIT_STATUS, WAIT_STATUS})
      $display("FAIL reset_mid_state got=%0d/%0d exp=%0d", st0, st1, WAIT_STATUS);
    else passes++;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_running_status();
    test_steal();
    test_realtime();
    test_channel();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
